// File: rtl/rom_load_pkg.sv
// Shared types and default geometry for the ROM download sequencer.
// Regions are packed back to back: CPU, then graphics, then colour PROM.
package rom_load_pkg;

    localparam int unsigned DefCpuSize  = 16384;
    localparam int unsigned DefGfxSize  = 4096;
    localparam int unsigned DefPromSize = 32;
    localparam int unsigned DefRstHold  = 16;

    localparam int unsigned DefGfxBase  = DefCpuSize;
    localparam int unsigned DefPromBase = DefCpuSize + DefGfxSize;
    localparam int unsigned DefTotal    = DefCpuSize + DefGfxSize + DefPromSize;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StDrain,
        StHold,
        StRun,
        StFault
    } state_e;

    typedef enum logic [1:0] {
        RegNone,
        RegCpu,
        RegGfx,
        RegProm
    } region_e;

endpackage

// File: rtl/rom_load_ctrl_if.sv
// Download bus between the HPS ioctl stream (master) and the ROM sequencer (slave),
// including the region write port fed into the core.
interface rom_load_ctrl_if;

    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr_cpu;
    logic        dn_wr_gfx;
    logic        dn_wr_prom;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  dn_addr, dn_data, dn_wr_cpu, dn_wr_gfx, dn_wr_prom
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output dn_addr, dn_data, dn_wr_cpu, dn_wr_gfx, dn_wr_prom
    );

endinterface

// File: rtl/rom_region_decode.sv
// Maps an image byte address onto a ROM region and its region-local offset.
// Anything at or beyond the end of the image (or above 64 KiB) decodes to no region.
module rom_region_decode
    import rom_load_pkg::*;
#(
    parameter int unsigned CPU_SIZE  = DefCpuSize,
    parameter int unsigned GFX_SIZE  = DefGfxSize,
    parameter int unsigned PROM_SIZE = DefPromSize
) (
    input  logic [24:0] addr,
    output region_e     region,
    output logic [15:0] offset,
    output logic        in_range
);

    localparam logic [24:0] GfxBase  = 25'(CPU_SIZE);
    localparam logic [24:0] PromBase = 25'(CPU_SIZE + GFX_SIZE);
    localparam logic [24:0] Total    = 25'(CPU_SIZE + GFX_SIZE + PROM_SIZE);

    always_comb begin
        region = RegNone;
        offset = '0;
        if (addr[24:16] == '0 && addr < Total) begin
            if (addr < GfxBase) begin
                region = RegCpu;
                offset = addr[15:0];
            end else if (addr < PromBase) begin
                region = RegGfx;
                offset = addr[15:0] - GfxBase[15:0];
            end else begin
                region = RegProm;
                offset = addr[15:0] - PromBase[15:0];
            end
        end
    end

    assign in_range = (region != RegNone);

endmodule

// File: rtl/rom_load_ctrl.sv
// Steers the HPS ROM download into the core's ROM regions, checksums it, and holds
// the core in reset until a complete, in-range image has landed and settled.
module rom_load_ctrl
    import rom_load_pkg::*;
#(
    parameter int unsigned CPU_SIZE  = DefCpuSize,
    parameter int unsigned GFX_SIZE  = DefGfxSize,
    parameter int unsigned PROM_SIZE = DefPromSize,
    parameter int unsigned RST_HOLD  = DefRstHold
) (
    input  logic           clk_sys,
    input  logic           reset,
    input  logic           soft_reset,
    rom_load_ctrl_if.slave bus,
    output logic           core_reset,
    output logic           load_done,
    output logic           load_error,
    output logic [7:0]     checksum
);

    localparam logic [16:0] TotalCnt = 17'(CPU_SIZE + GFX_SIZE + PROM_SIZE);
    localparam logic [15:0] HoldInit = 16'(RST_HOLD - 1);

    state_e      state_q;
    logic [16:0] count_q;
    logic [15:0] hold_q;
    logic        oor_q;
    logic [15:0] dn_addr_q;
    logic [7:0]  dn_data_q;
    logic        wr_cpu_q;
    logic        wr_gfx_q;
    logic        wr_prom_q;

    region_e     region;
    logic [15:0] offset;
    logic        in_range;
    logic        start_load;

    rom_region_decode #(
        .CPU_SIZE (CPU_SIZE),
        .GFX_SIZE (GFX_SIZE),
        .PROM_SIZE(PROM_SIZE)
    ) u_decode (
        .addr    (bus.ioctl_addr),
        .region  (region),
        .offset  (offset),
        .in_range(in_range)
    );

    // A new download may pre-empt any state except an active load/drain.
    assign start_load = bus.ioctl_download && (state_q inside {StIdle, StHold, StRun, StFault});

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= StIdle;
            count_q    <= '0;
            hold_q     <= '0;
            oor_q      <= 1'b0;
            dn_addr_q  <= '0;
            dn_data_q  <= '0;
            wr_cpu_q   <= 1'b0;
            wr_gfx_q   <= 1'b0;
            wr_prom_q  <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            checksum   <= '0;
            core_reset <= 1'b1;
        end else begin
            wr_cpu_q   <= 1'b0;
            wr_gfx_q   <= 1'b0;
            wr_prom_q  <= 1'b0;
            core_reset <= (state_q != StRun) | soft_reset;
            if (start_load) begin
                state_q    <= StLoad;
                count_q    <= '0;
                oor_q      <= 1'b0;
                checksum   <= '0;
                load_done  <= 1'b0;
                load_error <= 1'b0;
            end else begin
                unique case (state_q)
                    StLoad: begin
                        // The strobe on the cycle download drops is still taken.
                        if (bus.ioctl_wr) begin
                            if (in_range) begin
                                dn_addr_q <= offset;
                                dn_data_q <= bus.ioctl_dout;
                                wr_cpu_q  <= (region == RegCpu);
                                wr_gfx_q  <= (region == RegGfx);
                                wr_prom_q <= (region == RegProm);
                                checksum  <= checksum + bus.ioctl_dout;
                                if (count_q != '1) count_q <= count_q + 17'd1;
                            end else begin
                                oor_q <= 1'b1;
                            end
                        end
                        if (!bus.ioctl_download) state_q <= StDrain;
                    end
                    StDrain: begin
                        if (count_q == TotalCnt && !oor_q) begin
                            state_q <= StHold;
                            hold_q  <= HoldInit;
                        end else begin
                            state_q    <= StFault;
                            load_error <= 1'b1;
                        end
                    end
                    StHold: begin
                        if (hold_q == '0) begin
                            state_q   <= StRun;
                            load_done <= 1'b1;
                        end else begin
                            hold_q <= hold_q - 16'd1;
                        end
                    end
                    StIdle, StRun, StFault: ;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.dn_addr    = dn_addr_q;
    assign bus.dn_data    = dn_data_q;
    assign bus.dn_wr_cpu  = wr_cpu_q;
    assign bus.dn_wr_gfx  = wr_gfx_q;
    assign bus.dn_wr_prom = wr_prom_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Scenario bench for rom_load_ctrl: each driven in-range byte queues its expected
// region write, which the negedge monitor pops and compares when a strobe appears.
module tb_rom_load_ctrl;

    localparam logic [24:0] CpuEnd  = 25'h04000;
    localparam logic [24:0] GfxEnd  = 25'h05000;
    localparam logic [24:0] ImgEnd  = 25'h05020;
    localparam int          Total   = 32'h5020;
    localparam int          RstHold = 16;

    typedef struct packed {
        logic [1:0]  rid;
        logic [15:0] off;
        logic [7:0]  data;
        logic [31:0] cyc;
    } exp_t;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        soft_reset;
    logic        core_reset;
    logic        load_done;
    logic        load_error;
    logic [7:0]  checksum;
    logic [31:0] cyc = '0;
    logic [7:0]  sum_model;
    bit          mon_en = 1'b0;
    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];

    rom_load_ctrl_if bus();

    rom_load_ctrl dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .soft_reset(soft_reset),
        .bus       (bus),
        .core_reset(core_reset),
        .load_done (load_done),
        .load_error(load_error),
        .checksum  (checksum)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 32'd1;

    always @(negedge clk_sys) begin : monitor
        int n;
        exp_t e;
        logic [1:0] rid;
        if (mon_en) begin
            n = int'(bus.dn_wr_cpu) + int'(bus.dn_wr_gfx) + int'(bus.dn_wr_prom);
            if (n != 0) begin
                checks++;
                rid = bus.dn_wr_cpu ? 2'd1 : (bus.dn_wr_gfx ? 2'd2 : 2'd3);
                if (n > 1) begin
                    errors++;
                    $display("FAIL strobe_onehot: %0d strobes high at cycle %0d, required 1", n, cyc);
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: region %0d off %h at cycle %0d, required none",
                             rid, bus.dn_addr, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if ({rid, bus.dn_addr, bus.dn_data, cyc} !== {e.rid, e.off, e.data, e.cyc}) begin
                        errors++;
                        $display("FAIL region_write: got rgn %0d off %h data %h cyc %0d, required rgn %0d off %h data %h cyc %0d",
                                 rid, bus.dn_addr, bus.dn_data, cyc, e.rid, e.off, e.data, e.cyc);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic drive_byte(input logic [24:0] a, input logic [7:0] d, input bit last);
        exp_t e;
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        if (last) bus.ioctl_download = 1'b0;
        if (a < ImgEnd) begin
            e.rid  = (a < CpuEnd) ? 2'd1 : ((a < GfxEnd) ? 2'd2 : 2'd3);
            e.off  = (a < CpuEnd) ? a[15:0] : ((a < GfxEnd) ? a[15:0] - 16'h4000 : a[15:0] - 16'h5000);
            e.data = d;
            e.cyc  = cyc + 32'd1;
            exp_q.push_back(e);
            sum_model = sum_model + d;
        end
        tick();
        bus.ioctl_wr = 1'b0;
    endtask

    // Streams n bytes from address 0; the last byte coincides with download falling.
    task automatic load_image(input int n, input bit rnd, input bit oor);
        sum_model = '0;
        for (int i = 0; i < n; i++) begin
            if (oor && i == 100) drive_byte(25'h05020, 8'hAA, 1'b0);
            if (oor && i == 200) drive_byte(25'h10000, 8'h55, 1'b0);
            drive_byte(25'(i), rnd ? 8'($urandom) : 8'(i), i == n - 1);
        end
    endtask

    task automatic start_download();
        bus.ioctl_download = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        mon_en = 1'b1;
        checks++;
        if ({core_reset, load_done, load_error, checksum} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_status: got rst %b done %b err %b sum %h, required 1 0 0 00",
                     core_reset, load_done, load_error, checksum);
        end
        checks++;
        if ({bus.dn_addr, bus.dn_data, bus.dn_wr_cpu, bus.dn_wr_gfx, bus.dn_wr_prom} !== 29'd0) begin
            errors++;
            $display("FAIL reset_dn: got addr %h data %h wr %b%b%b, required all zero",
                     bus.dn_addr, bus.dn_data, bus.dn_wr_cpu, bus.dn_wr_gfx, bus.dn_wr_prom);
        end
        reset = 1'b0;
        // Strobes without download must be ignored while idle.
        for (int i = 0; i < 20; i++) begin
            bus.ioctl_wr   = i[0];
            bus.ioctl_addr = 25'($urandom_range(0, Total - 1));
            tick();
        end
        bus.ioctl_wr = 1'b0;
        checks++;
        if ({core_reset, load_done} !== 2'b10) begin
            errors++;
            $display("FAIL idle_status: got rst %b done %b, required 1 0", core_reset, load_done);
        end
    endtask

    task automatic test_short_load();
        start_download();
        load_image(Total - 1, 1'b1, 1'b0);
        tick();
        checks++;
        if ({load_error, load_done} !== 2'b10) begin
            errors++;
            $display("FAIL short_fault: got err %b done %b, required 1 0", load_error, load_done);
        end
        repeat (10) tick();
        checks++;
        if (core_reset !== 1'b1) begin
            errors++;
            $display("FAIL short_core_reset: got %b, required 1", core_reset);
        end
    endtask

    task automatic test_full_load();
        start_download();
        checks++;
        if ({load_error, checksum} !== 9'd0) begin
            errors++;
            $display("FAIL full_entry_clear: got err %b sum %h, required 0 00", load_error, checksum);
        end
        load_image(Total, 1'b0, 1'b0);
        checks++;
        if (checksum !== sum_model) begin
            errors++;
            $display("FAIL full_checksum: got %h, required %h", checksum, sum_model);
        end
        for (int k = 1; k <= RstHold + 2; k++) begin
            tick();
            checks++;
            if (core_reset !== (k < RstHold + 2)) begin
                errors++;
                $display("FAIL release_timing: core_reset %b at %0d cycles after drop, required %b",
                         core_reset, k, k < RstHold + 2);
            end
        end
        checks++;
        if ({load_done, load_error, exp_q.size() == 0} !== 3'b101) begin
            errors++;
            $display("FAIL full_status: got done %b err %b pending %0d, required 1 0 0",
                     load_done, load_error, exp_q.size());
        end
    endtask

    task automatic test_soft_reset();
        for (int i = 0; i < 6; i++) begin
            soft_reset = (i < 3);
            tick();
            checks++;
            if (core_reset !== (i < 3)) begin
                errors++;
                $display("FAIL soft_reset: core_reset %b at step %0d, required %b", core_reset, i, i < 3);
            end
        end
        checks++;
        if (load_done !== 1'b1) begin
            errors++;
            $display("FAIL soft_reset_run: load_done %b, required 1", load_done);
        end
    endtask

    task automatic test_reload_run_hold();
        start_download();
        checks++;
        if ({core_reset, load_done, checksum} !== 10'd0) begin
            errors++;
            $display("FAIL run_reload_entry: got rst %b done %b sum %h, required 0 0 00",
                     core_reset, load_done, checksum);
        end
        tick();
        checks++;
        if (core_reset !== 1'b1) begin
            errors++;
            $display("FAIL run_reload_reset: got %b, required 1", core_reset);
        end
        load_image(Total, 1'b1, 1'b0);
        checks++;
        if (checksum !== sum_model) begin
            errors++;
            $display("FAIL reload_checksum: got %h, required %h", checksum, sum_model);
        end
        repeat (5) tick();
        start_download();
        checks++;
        if ({checksum, load_done, load_error, core_reset} !== 11'b1) begin
            errors++;
            $display("FAIL hold_reload: got sum %h done %b err %b rst %b, required 00 0 0 1",
                     checksum, load_done, load_error, core_reset);
        end
    endtask

    task automatic test_out_of_range();
        load_image(Total, 1'b1, 1'b1);
        checks++;
        if (checksum !== sum_model) begin
            errors++;
            $display("FAIL oor_checksum: got %h, required %h", checksum, sum_model);
        end
        tick();
        checks++;
        if ({load_error, load_done, core_reset, exp_q.size() == 0} !== 4'b1011) begin
            errors++;
            $display("FAIL oor_fault: got err %b done %b rst %b pending %0d, required 1 0 1 0",
                     load_error, load_done, core_reset, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_load();
        start_download();
        sum_model = '0;
        for (int i = 0; i < 10; i++) drive_byte(25'(i), 8'hC0 + 8'(i), 1'b0);
        reset          = 1'b1;
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 25'd10;
        tick();
        checks++;
        if ({bus.dn_addr, bus.dn_data, bus.dn_wr_cpu, bus.dn_wr_gfx, bus.dn_wr_prom, checksum,
             load_done, load_error, core_reset} !== 40'd1) begin
            errors++;
            $display("FAIL mid_load_reset: got addr %h data %h wr %b%b%b sum %h done %b err %b rst %b, required zeros rst 1",
                     bus.dn_addr, bus.dn_data, bus.dn_wr_cpu, bus.dn_wr_gfx, bus.dn_wr_prom, checksum,
                     load_done, load_error, core_reset);
        end
        reset              = 1'b0;
        bus.ioctl_download = 1'b0;
        repeat (8) tick();
        bus.ioctl_wr = 1'b0;
        checks++;
        if ({core_reset, exp_q.size() == 0} !== 2'b11) begin
            errors++;
            $display("FAIL post_reset_idle: got rst %b pending %0d, required 1 0", core_reset, exp_q.size());
        end
    endtask

    initial begin
        reset              = 1'b1;
        soft_reset         = 1'b0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        sum_model          = '0;
        test_reset();
        test_short_load();
        test_full_load();
        test_soft_reset();
        test_reload_run_hold();
        test_out_of_range();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
